// File: rtl/mem_stream_loader.sv
// mem_stream_loader: moves 32-bit words between a byte stream and a 1-cycle-latency data RAM
// cmd_*   : command handshake (direction, start byte address, word count), abort_i cancels
// rx_*    : inbound byte stream packed little-endian into words written to RAM
// tx_*    : outbound byte stream serialized little-endian from words read from RAM
// en/addr/wdata/we/be/rdata : single-port RAM initiator, busy_o/done_o : status
module mem_stream_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  abort_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wdata_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  input  logic [31:0]           rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SEND, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0] rem;
  logic [1:0] byte_cnt;
  logic [31:0] data;
  logic last, rx_hs, tx_hs, accept;
  assign last   = rem == LEN_WIDTH'(1);
  assign rx_hs  = state == WR_COLLECT && rx_valid_i;
  assign tx_hs  = state == RD_SEND && tx_ready_i;
  assign accept = state == IDLE && cmd_valid_i && !abort_i;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (abort_i) state_nx = IDLE;
    else
      case (state)
        IDLE:       if (cmd_valid_i) state_nx = cmd_len_i == '0 ? DONE : cmd_write_i ? WR_COLLECT : RD_ISSUE;
        WR_COLLECT: if (rx_valid_i && byte_cnt == 2'd3) state_nx = WR_ISSUE;
        WR_ISSUE:   state_nx = last ? DONE : WR_COLLECT;
        RD_ISSUE:   state_nx = RD_WAIT;
        RD_WAIT:    state_nx = RD_SEND;
        RD_SEND:    if (tx_ready_i && byte_cnt == 2'd3) state_nx = last ? DONE : RD_ISSUE;
        default:    state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      addr     <= '0;
      rem      <= '0;
      byte_cnt <= '0;
      data     <= '0;
    end else if (abort_i) begin
      byte_cnt <= '0;
    end else if (accept) begin
      addr     <= cmd_addr_i & ~ADDR_WIDTH'(3);
      rem      <= cmd_len_i;
      byte_cnt <= '0;
    end else if (rx_hs) begin
      data[8*byte_cnt +: 8] <= rx_data_i;
      byte_cnt              <= byte_cnt + 2'd1;
    end else if (state == WR_ISSUE || (tx_hs && byte_cnt == 2'd3)) begin
      addr     <= addr + ADDR_WIDTH'(4);
      rem      <= rem - LEN_WIDTH'(1);
      byte_cnt <= '0;
    end else if (tx_hs) begin
      byte_cnt <= byte_cnt + 2'd1;
    end else if (state == RD_WAIT) begin
      data <= rdata_i;
    end
  end
  assign cmd_ready_o = state == IDLE;
  assign busy_o      = state != IDLE;
  assign rx_ready_o  = state == WR_COLLECT;
  assign tx_valid_o  = state == RD_SEND;
  assign en_o        = state == WR_ISSUE || state == RD_ISSUE;
  assign we_o        = state == WR_ISSUE;
  assign be_o        = {4{en_o}};
  assign done_o      = state == DONE;
  assign addr_o      = addr;
  assign wdata_o     = data;
  assign tx_data_o   = data[8*byte_cnt +: 8];
endmodule

// File: tb/tb_mem_stream_loader.sv
// tb_mem_stream_loader: directed self-checking bench for mem_stream_loader with a behavioural RAM
module tb_mem_stream_loader;
  logic clk, rstn_i, cmd_valid_i, cmd_ready_o, cmd_write_i, abort_i;
  logic [14:0] cmd_addr_i, addr_o;
  logic [12:0] cmd_len_i;
  logic [7:0] rx_data_i, tx_data_o;
  logic rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i, en_o, we_o, busy_o, done_o;
  logic [31:0] wdata_o, rdata_i;
  logic [3:0] be_o;
  int pass_n = 0, total_n = 0;
  logic [31:0] mem [0:8191];
  logic [14:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [3:0] wq_be[$];
  int wq_c[$];
  int rd_n = 0, done_n = 0, done_c = 0, cycle = 0;
  mem_stream_loader dut (
    .clk(clk), .rstn_i(rstn_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .abort_i(abort_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .en_o(en_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o), .be_o(be_o),
    .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cycle++;
    if (en_o && we_o) begin
      for (int b = 0; b < 4; b++) if (be_o[b]) mem[addr_o[14:2]][8*b +: 8] = wdata_o[8*b +: 8];
      wq_a.push_back(addr_o);
      wq_d.push_back(wdata_o);
      wq_be.push_back(be_o);
      wq_c.push_back(cycle);
    end
    if (en_o && !we_o) begin
      rd_n++;
      rdata_i <= mem[addr_o[14:2]];
    end
    if (done_o) begin
      done_n++;
      done_c = cycle;
    end
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_log;
    wq_a.delete();
    wq_d.delete();
    wq_be.delete();
    wq_c.delete();
    rd_n = 0;
    done_n = 0;
  endtask
  task automatic cmd(input logic w, input logic [14:0] a, input logic [12:0] l);
    cmd_valid_i = 1;
    cmd_write_i = w;
    cmd_addr_i = a;
    cmd_len_i = l;
    cyc;
    cmd_valid_i = 0;
  endtask
  task automatic send(input logic [63:0] s, input int n);
    int i = 0, t = 0;
    logic r;
    while (i < n && t < 100) begin
      rx_data_i = s[8*i +: 8];
      rx_valid_i = 1;
      r = rx_ready_o;
      cyc;
      if (r) i++;
      t++;
    end
    rx_valid_i = 0;
    if (i < n) begin
      total_n++;
      $display("FAIL send_timeout got %0d bytes need %0d", i, n);
    end
  endtask
  task automatic wait_idle;
    int t = 0;
    while (busy_o && t < 200) begin
      cyc;
      t++;
    end
    if (busy_o) begin
      total_n++;
      $display("FAIL idle_timeout busy_o still high");
    end
  endtask
  task automatic rd_collect(output logic [31:0] w, output int got);
    int t = 0;
    logic r;
    logic [7:0] d;
    got = 0;
    w = 0;
    tx_ready_i = 1;
    while (got < 4 && t < 40) begin
      r = tx_valid_o;
      d = tx_data_o;
      cyc;
      if (r) begin
        w[8*got +: 8] = d;
        got++;
      end
      t++;
    end
    tx_ready_i = 0;
  endtask
  task automatic test_reset;
    rstn_i = 0;
    #2;
    total_n++;
    if ({cmd_ready_o, busy_o, rx_ready_o, tx_valid_o, en_o, we_o, be_o, done_o} !== 11'b100_0000_0000)
      $display("FAIL reset_ctrl got %b exp %b", {cmd_ready_o, busy_o, rx_ready_o, tx_valid_o, en_o, we_o, be_o, done_o}, 11'b100_0000_0000);
    else pass_n++;
    total_n++;
    if ({addr_o, wdata_o, tx_data_o} !== '0) $display("FAIL reset_data got %h exp 0", {addr_o, wdata_o, tx_data_o});
    else pass_n++;
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1;
    cyc;
  endtask
  task automatic test_reset_mid_write;
    clear_log;
    cmd(1, 15'h0300, 1);
    send(64'h2211, 2);
    rstn_i = 0;
    #1;
    total_n++;
    if ({cmd_ready_o, busy_o, rx_ready_o, en_o, done_o} !== 5'b10000)
      $display("FAIL midrst_ctrl got %b exp %b", {cmd_ready_o, busy_o, rx_ready_o, en_o, done_o}, 5'b10000);
    else pass_n++;
    total_n++;
    if ({addr_o, wdata_o} !== '0) $display("FAIL midrst_data got %h exp 0", {addr_o, wdata_o});
    else pass_n++;
    #1;
    rstn_i = 1;
    cmd(1, 15'h0300, 1);
    total_n++;
    if ({busy_o, rx_ready_o} !== 2'b11) $display("FAIL midrst_accept got %b exp 11", {busy_o, rx_ready_o});
    else pass_n++;
    send(64'hA4A3A2A1, 4);
    wait_idle;
    total_n++;
    if (wq_a.size() !== 1) $display("FAIL midrst_nwr got %0d exp 1", wq_a.size());
    else pass_n++;
    total_n++;
    if ({wq_a[0], wq_d[0]} !== {15'h0300, 32'hA4A3A2A1}) $display("FAIL midrst_word got %h/%h exp 0300/a4a3a2a1", wq_a[0], wq_d[0]);
    else pass_n++;
  endtask
  task automatic test_write;
    clear_log;
    cmd(1, 15'h0100, 2);
    send(64'h8877665544332211, 8);
    wait_idle;
    total_n++;
    if (wq_a.size() !== 2) $display("FAIL wr_nwr got %0d exp 2", wq_a.size());
    else pass_n++;
    total_n++;
    if ({wq_a[0], wq_d[0], wq_be[0]} !== {15'h0100, 32'h44332211, 4'hF}) $display("FAIL wr_word0 got %h/%h/%h exp 0100/44332211/f", wq_a[0], wq_d[0], wq_be[0]);
    else pass_n++;
    total_n++;
    if ({wq_a[1], wq_d[1], wq_be[1]} !== {15'h0104, 32'h88776655, 4'hF}) $display("FAIL wr_word1 got %h/%h/%h exp 0104/88776655/f", wq_a[1], wq_d[1], wq_be[1]);
    else pass_n++;
    total_n++;
    if (wq_c[1] - wq_c[0] !== 5) $display("FAIL wr_rate got %0d exp 5", wq_c[1] - wq_c[0]);
    else pass_n++;
    total_n++;
    if (done_n !== 1) $display("FAIL wr_done_n got %0d exp 1", done_n);
    else pass_n++;
    total_n++;
    if (done_c !== wq_c[1] + 1) $display("FAIL wr_done_time got %0d exp %0d", done_c, wq_c[1] + 1);
    else pass_n++;
  endtask
  task automatic test_read;
    int t = 0, got;
    logic [31:0] w;
    clear_log;
    mem[15'h0200 >> 2] = 32'hDEADBEEF;
    tx_ready_i = 0;
    cmd(0, 15'h0200, 1);
    while (!tx_valid_o && t < 20) begin
      cyc;
      t++;
    end
    for (int k = 0; k < 3; k++) begin
      total_n++;
      if ({tx_valid_o, tx_data_o} !== 9'h1EF) $display("FAIL rd_stall%0d got %b/%h exp 1/ef", k, tx_valid_o, tx_data_o);
      else pass_n++;
      cyc;
    end
    rd_collect(w, got);
    total_n++;
    if ({got, w} !== {32'd4, 32'hDEADBEEF}) $display("FAIL rd_bytes got %0d/%h exp 4/deadbeef", got, w);
    else pass_n++;
    wait_idle;
    total_n++;
    if ({rd_n, done_n} !== {32'd1, 32'd1}) $display("FAIL rd_counts got rd %0d done %0d exp 1 1", rd_n, done_n);
    else pass_n++;
  endtask
  task automatic test_wrap;
    clear_log;
    cmd(1, 15'h7FFE, 2);
    send(64'h0807060504030201, 8);
    wait_idle;
    total_n++;
    if ({wq_a[0], wq_d[0]} !== {15'h7FFC, 32'h04030201}) $display("FAIL wrap_word0 got %h/%h exp 7ffc/04030201", wq_a[0], wq_d[0]);
    else pass_n++;
    total_n++;
    if ({wq_a[1], wq_d[1]} !== {15'h0000, 32'h08070605}) $display("FAIL wrap_word1 got %h/%h exp 0000/08070605", wq_a[1], wq_d[1]);
    else pass_n++;
  endtask
  task automatic test_zero_len;
    clear_log;
    cmd(1, 15'h0100, 0);
    total_n++;
    if ({busy_o, done_o, en_o} !== 3'b110) $display("FAIL zlen_done got %b exp 110", {busy_o, done_o, en_o});
    else pass_n++;
    cyc;
    total_n++;
    if ({busy_o, done_o} !== 2'b00) $display("FAIL zlen_idle got %b exp 00", {busy_o, done_o});
    else pass_n++;
    total_n++;
    if ({wq_a.size(), rd_n, done_n} !== {32'd0, 32'd0, 32'd1}) $display("FAIL zlen_counts got %0d %0d %0d exp 0 0 1", wq_a.size(), rd_n, done_n);
    else pass_n++;
  endtask
  task automatic test_abort;
    int got;
    logic [31:0] w;
    clear_log;
    cmd(1, 15'h0100, 1);
    send(64'hCCBBAA, 3);
    abort_i = 1;
    cyc;
    abort_i = 0;
    total_n++;
    if ({busy_o, cmd_ready_o} !== 2'b01) $display("FAIL abort_idle got %b exp 01", {busy_o, cmd_ready_o});
    else pass_n++;
    cyc;
    total_n++;
    if ({wq_a.size(), rd_n, done_n} !== {32'd0, 32'd0, 32'd0}) $display("FAIL abort_counts got %0d %0d %0d exp 0 0 0", wq_a.size(), rd_n, done_n);
    else pass_n++;
    abort_i = 1;
    cmd(1, 15'h0100, 1);
    abort_i = 0;
    total_n++;
    if (busy_o !== 1'b0) $display("FAIL abort_prio got %b exp 0", busy_o);
    else pass_n++;
    cmd(0, 15'h0100, 1);
    rd_collect(w, got);
    wait_idle;
    total_n++;
    if ({got, w} !== {32'd4, 32'h44332211}) $display("FAIL abort_readback got %0d/%h exp 4/44332211", got, w);
    else pass_n++;
  endtask
  initial begin
    rstn_i = 1;
    cmd_valid_i = 0;
    cmd_write_i = 0;
    cmd_addr_i = 0;
    cmd_len_i = 0;
    abort_i = 0;
    rx_data_i = 0;
    rx_valid_i = 0;
    tx_ready_i = 0;
    rdata_i = 0;
    #1;
    test_reset;
    test_reset_mid_write;
    test_write;
    test_read;
    test_wrap;
    test_zero_len;
    test_abort;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
